// File: rtl/rst_cipher_pkg.sv
// Shared types, character constants and symbol helpers for the rotating-table cipher.
package rst_cipher_pkg;

    typedef logic [5:0] sym_t;

    typedef enum logic {
        NOKEY = 1'b0,
        READY = 1'b1
    } key_state_t;

    localparam logic [7:0] CH_A   = 8'h41;
    localparam logic [7:0] CH_Z   = 8'h5A;
    localparam logic [7:0] CH_LA  = 8'h61;
    localparam logic [7:0] CH_LZ  = 8'h7A;
    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_9   = 8'h39;
    localparam logic [7:0] CH_NUL = 8'h00;

    localparam sym_t SYM_DIGIT0 = 6'd26;
    localparam sym_t SYM_MAX    = 6'd35;

    function automatic logic is_alnum(input logic [7:0] ch);
        return ((ch >= CH_A)  && (ch <= CH_Z))  ||
               ((ch >= CH_LA) && (ch <= CH_LZ)) ||
               ((ch >= CH_0)  && (ch <= CH_9));
    endfunction

    // Non-alphanumeric input maps to 0; callers gate with is_alnum.
    function automatic sym_t char_to_sym(input logic [7:0] ch);
        sym_t s;
        if ((ch >= CH_A) && (ch <= CH_Z)) begin
            s = sym_t'(ch - CH_A);
        end else if ((ch >= CH_LA) && (ch <= CH_LZ)) begin
            s = sym_t'(ch - CH_LA);
        end else if ((ch >= CH_0) && (ch <= CH_9)) begin
            s = sym_t'(ch - CH_0) + SYM_DIGIT0;
        end else begin
            s = 6'd0;
        end
        return s;
    endfunction

    function automatic logic [7:0] sym_to_char(input sym_t s);
        logic [7:0] ch;
        if (s < SYM_DIGIT0) begin
            ch = CH_A + {2'b00, s};
        end else begin
            ch = CH_0 + {2'b00, s - SYM_DIGIT0};
        end
        return ch;
    endfunction

endpackage

// File: rtl/rst_cipher_stream_if.sv
// Key-install and valid/ready symbol stream bundle of the rotating-table cipher.
interface rst_cipher_stream_if #(
    parameter int N_DIM = 6
) ();
    localparam int KEY_LEN = 2 * N_DIM;

    logic [8*KEY_LEN-1:0] key;
    logic                 key_valid;
    logic                 key_installed;
    logic                 err_invalid_key;
    logic                 mode;
    logic                 in_valid;
    logic                 in_ready;
    logic [15:0]          in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [15:0]          out_data;
    logic                 out_err_sym;
    logic                 out_err_nokey;

    modport master (
        output key, key_valid, mode, in_valid, in_data, out_ready,
        input  key_installed, err_invalid_key, in_ready, out_valid,
               out_data, out_err_sym, out_err_nokey
    );

    modport slave (
        input  key, key_valid, mode, in_valid, in_data, out_ready,
        output key_installed, err_invalid_key, in_ready, out_valid,
               out_data, out_err_sym, out_err_nokey
    );
endinterface

// File: rtl/rst_key_schedule.sv
// Row/column key registers: legality check on install, rotate by one on each strobe.
module rst_key_schedule
    import rst_cipher_pkg::*;
#(
    parameter int N_DIM = 6,
    localparam int KEY_LEN = 2 * N_DIM
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8*KEY_LEN-1:0] key,
    input  logic                 key_valid,
    input  logic                 rotate,
    output logic [7:0]           row_key [N_DIM],
    output logic [7:0]           col_key [N_DIM],
    output logic                 key_installed,
    output logic                 err_invalid_key
);

    logic [7:0] row_new_s [N_DIM];
    logic [7:0] col_new_s [N_DIM];
    logic [7:0] row_r     [N_DIM];
    logic [7:0] col_r     [N_DIM];
    logic       key_ok_s;
    logic       err_r;
    key_state_t state_r;

    // Split the key string (first char in the MSB byte) and check legality.
    always_comb begin
        key_ok_s = 1'b1;
        for (int i = 0; i < N_DIM; i++) begin
            row_new_s[i] = key[8*(KEY_LEN-2*i)-1 -: 8];
            col_new_s[i] = key[8*(KEY_LEN-2*i-1)-1 -: 8];
        end
        for (int i = 0; i < N_DIM; i++) begin
            if (!is_alnum(row_new_s[i]) || !is_alnum(col_new_s[i])) begin
                key_ok_s = 1'b0;
            end else begin
                key_ok_s = key_ok_s;
            end
            for (int j = i + 1; j < N_DIM; j++) begin
                if ((row_new_s[i] == row_new_s[j]) || (col_new_s[i] == col_new_s[j])) begin
                    key_ok_s = 1'b0;
                end else begin
                    key_ok_s = key_ok_s;
                end
            end
        end
    end

    // Key FSM plus table registers; an install always wins over a rotate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= NOKEY;
            err_r   <= 1'b0;
            for (int i = 0; i < N_DIM; i++) begin
                row_r[i] <= 8'h00;
                col_r[i] <= 8'h00;
            end
        end else begin
            err_r <= key_valid && !key_ok_s;
            case (state_r)
                NOKEY:   state_r <= (key_valid && key_ok_s) ? READY : NOKEY;
                READY:   state_r <= (key_valid && !key_ok_s) ? NOKEY : READY;
                default: state_r <= NOKEY;
            endcase
            if (key_valid) begin
                if (key_ok_s) begin
                    row_r <= row_new_s;
                    col_r <= col_new_s;
                end else begin
                    row_r <= row_r;
                    col_r <= col_r;
                end
            end else if (rotate) begin
                row_r[0] <= row_r[N_DIM-1];
                col_r[0] <= col_r[N_DIM-1];
                for (int i = 1; i < N_DIM; i++) begin
                    row_r[i] <= row_r[i-1];
                    col_r[i] <= col_r[i-1];
                end
            end else begin
                row_r <= row_r;
                col_r <= col_r;
            end
        end
    end

    assign row_key         = row_r;
    assign col_key         = col_r;
    assign key_installed   = (state_r == READY);
    assign err_invalid_key = err_r;

endmodule

// File: rtl/rst_cipher_stream.sv
// Streaming rotating-table cipher: symbol mapping, decrypt search, one-deep output register.
module rst_cipher_stream
    import rst_cipher_pkg::*;
#(
    parameter int N_DIM  = 6,
    parameter int DEC_EN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    rst_cipher_stream_if.slave  bus
);

    localparam int   IDX_W = $clog2(N_DIM);
    localparam sym_t N_SYM = sym_t'(N_DIM);

    logic [7:0]       row_key [N_DIM];
    logic [7:0]       col_key [N_DIM];
    logic             key_installed_s;
    logic             err_invalid_key_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             rotate_s;
    logic             mode_s;
    sym_t             sym_s;
    sym_t             r_full_s;
    sym_t             c_full_s;
    logic             row_hit_s;
    logic             col_hit_s;
    logic [IDX_W-1:0] row_idx_s;
    logic [IDX_W-1:0] col_idx_s;
    sym_t             dec_sym_s;
    logic [15:0]      res_data_s;
    logic             res_err_sym_s;
    logic             res_err_nokey_s;
    logic             out_valid_r;
    logic [15:0]      out_data_r;
    logic             out_err_sym_r;
    logic             out_err_nokey_r;

    rst_key_schedule #(.N_DIM(N_DIM)) u_key_schedule (
        .clk             (clk),
        .rst_n           (rst_n),
        .key             (bus.key),
        .key_valid       (bus.key_valid),
        .rotate          (rotate_s),
        .row_key         (row_key),
        .col_key         (col_key),
        .key_installed   (key_installed_s),
        .err_invalid_key (err_invalid_key_s)
    );

    assign in_ready_s = (!out_valid_r || bus.out_ready) && !bus.key_valid;
    assign accept_s   = bus.in_valid && in_ready_s;

    // Compute the result beat for the current input from the pre-rotation table.
    always_comb begin
        mode_s          = (DEC_EN != 0) ? bus.mode : 1'b0;
        sym_s           = char_to_sym(bus.in_data[7:0]);
        r_full_s        = sym_s / N_SYM;
        c_full_s        = sym_s % N_SYM;
        row_hit_s       = 1'b0;
        col_hit_s       = 1'b0;
        row_idx_s       = '0;
        col_idx_s       = '0;
        res_data_s      = 16'h0000;
        res_err_sym_s   = 1'b0;
        res_err_nokey_s = 1'b0;
        for (int i = 0; i < N_DIM; i++) begin
            if (row_key[i] == bus.in_data[15:8]) begin
                row_hit_s = 1'b1;
                row_idx_s = IDX_W'(i);
            end else begin
                row_hit_s = row_hit_s;
            end
            if (col_key[i] == bus.in_data[7:0]) begin
                col_hit_s = 1'b1;
                col_idx_s = IDX_W'(i);
            end else begin
                col_hit_s = col_hit_s;
            end
        end
        dec_sym_s = sym_t'(row_idx_s) * N_SYM + sym_t'(col_idx_s);
        if (!key_installed_s) begin
            res_err_nokey_s = 1'b1;
        end else if (mode_s) begin
            if (row_hit_s && col_hit_s && (dec_sym_s <= SYM_MAX)) begin
                res_data_s = {CH_NUL, sym_to_char(dec_sym_s)};
            end else begin
                res_err_sym_s = 1'b1;
            end
        end else if (is_alnum(bus.in_data[7:0])) begin
            res_data_s = {row_key[r_full_s[IDX_W-1:0]], col_key[c_full_s[IDX_W-1:0]]};
        end else begin
            res_err_sym_s = 1'b1;
        end
        rotate_s = accept_s && !res_err_sym_s && !res_err_nokey_s;
    end

    // Single output register: load on accept, drop valid once the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r     <= 1'b0;
            out_data_r      <= 16'h0000;
            out_err_sym_r   <= 1'b0;
            out_err_nokey_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r     <= 1'b1;
            out_data_r      <= res_data_s;
            out_err_sym_r   <= res_err_sym_s;
            out_err_nokey_r <= res_err_nokey_s;
        end else if (bus.out_ready) begin
            out_valid_r     <= 1'b0;
        end else begin
            out_valid_r     <= out_valid_r;
        end
    end

    assign bus.in_ready        = in_ready_s;
    assign bus.out_valid       = out_valid_r;
    assign bus.out_data        = out_data_r;
    assign bus.out_err_sym     = out_err_sym_r;
    assign bus.out_err_nokey   = out_err_nokey_r;
    assign bus.key_installed   = key_installed_s;
    assign bus.err_invalid_key = err_invalid_key_s;

endmodule

// File: tb/tb_rst_cipher_stream.sv
// Directed bench for rst_cipher_stream with key "ABCDEFGHIJKL" (R=ACEGIK, C=BDFHJL).
module tb_rst_cipher_stream;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    localparam logic [95:0] KEY_GOOD = "ABCDEFGHIJKL";
    localparam logic [95:0] KEY_BADC = "ABCDEFGHIJ?L";
    localparam logic [95:0] KEY_DUPR = "ABADEFGHIJKL";

    rst_cipher_stream_if #(.N_DIM(6)) bus ();

    rst_cipher_stream #(.N_DIM(6), .DEC_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic install_key(input logic [95:0] k);
        bus.key       = k;
        bus.key_valid = 1'b1;
        bus.in_valid  = 1'b0;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic m);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.mode     = m;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [5:0] obs;
        obs = {bus.out_valid, bus.out_err_sym, bus.out_err_nokey,
               bus.key_installed, bus.err_invalid_key, |bus.out_data};
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000", obs);
        end
    endtask

    task automatic test_encrypt;
        logic [7:0]  hello [5] = '{"H", "e", "l", "l", "o"};
        logic [15:0] exp_h [5] = '{"CD", "KH", "KH", "IF", "IJ"};
        logic [7:0]  rk [6] = '{"A", "C", "E", "G", "I", "K"};
        logic [7:0]  ck [6] = '{"B", "D", "F", "H", "J", "L"};
        logic [7:0]  tr;
        logic [7:0]  tc;
        logic [7:0]  ch;
        int          s;
        install_key(KEY_GOOD);
        checks++;
        if (bus.key_installed !== 1'b1) begin
            errors++;
            $display("FAIL install_good: got %b expected 1", bus.key_installed);
        end
        bus.mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = {8'h00, hello[i]};
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_h[i] || bus.out_err_sym !== 1'b0) begin
                errors++;
                $display("FAIL enc_hello[%0d]: got v=%b %h expected v=1 %h", i, bus.out_valid, bus.out_data, exp_h[i]);
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        // Sweep 0..9 then A..Z against a rotating-table reference.
        install_key(KEY_GOOD);
        for (int i = 0; i < 36; i++) begin
            if (i < 10) begin
                ch = 8'h30 + 8'(i);
                s  = 26 + i;
            end else begin
                ch = 8'h41 + 8'(i - 10);
                s  = i - 10;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = {8'h00, ch};
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== {rk[s/6], ck[s%6]}) begin
                errors++;
                $display("FAIL enc_sweep[%c]: got %h expected %h", ch, bus.out_data, {rk[s/6], ck[s%6]});
            end
            tr = rk[5];
            tc = ck[5];
            for (int j = 5; j > 0; j--) begin
                rk[j] = rk[j-1];
                ck[j] = ck[j-1];
            end
            rk[0] = tr;
            ck[0] = tc;
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_decrypt;
        logic [15:0] pairs [4] = '{"CD", "KH", "CA", "IJ"};
        logic [15:0] exp_d [4] = '{16'h0048, 16'h0045, 16'h0000, 16'h0041};
        logic        exp_e [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        install_key(KEY_GOOD);
        for (int i = 0; i < 4; i++) begin
            send(pairs[i], 1'b1);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[i] || bus.out_err_sym !== exp_e[i]) begin
                errors++;
                $display("FAIL dec[%0d]: got %h err=%b expected %h err=%b", i, bus.out_data, bus.out_err_sym, exp_d[i], exp_e[i]);
            end
        end
        bus.mode = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_illegal_symbol;
        install_key(KEY_GOOD);
        send({8'h00, "-"}, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_err_sym !== 1'b1 || bus.out_data !== 16'h0000) begin
            errors++;
            $display("FAIL bad_sym: got v=%b err=%b %h expected v=1 err=1 0000", bus.out_valid, bus.out_err_sym, bus.out_data);
        end
        send({8'h00, "H"}, 1'b0);
        checks++;
        if (bus.out_err_sym !== 1'b0 || bus.out_data !== "CD") begin
            errors++;
            $display("FAIL after_bad_sym: got err=%b %h expected err=0 %h", bus.out_err_sym, bus.out_data, 16'("CD"));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_invalid_key;
        logic [95:0] bad [2];
        bad[0] = KEY_BADC;
        bad[1] = KEY_DUPR;
        for (int i = 0; i < 2; i++) begin
            install_key(KEY_GOOD);
            bus.key       = bad[i];
            bus.key_valid = 1'b1;
            bus.in_valid  = 1'b1;
            bus.in_data   = {8'h00, "H"};
            #1;
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL key_priority[%0d]: got in_ready=%b expected 0", i, bus.in_ready);
            end
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
            bus.key_valid = 1'b0;
            checks++;
            if (bus.err_invalid_key !== 1'b1 || bus.key_installed !== 1'b0) begin
                errors++;
                $display("FAIL bad_key[%0d]: got err=%b inst=%b expected err=1 inst=0", i, bus.err_invalid_key, bus.key_installed);
            end
            send({8'h00, "H"}, 1'b0);
            checks++;
            if (bus.err_invalid_key !== 1'b0 || bus.out_err_nokey !== 1'b1 || bus.out_data !== 16'h0000) begin
                errors++;
                $display("FAIL nokey[%0d]: got pulse=%b nokey=%b %h expected 0 1 0000", i, bus.err_invalid_key, bus.out_err_nokey, bus.out_data);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        install_key(KEY_GOOD);
        bus.out_ready = 1'b0;
        bus.mode      = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = {8'h00, "H"};
        @(posedge clk); #1;
        bus.in_data   = {8'h00, "e"};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== "CD" || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d]: got v=%b %h rdy=%b expected v=1 %h rdy=0", i, bus.out_valid, bus.out_data, bus.in_ready, 16'("CD"));
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== "KH") begin
            errors++;
            $display("FAIL release: got v=%b %h expected v=1 %h", bus.out_valid, bus.out_data, 16'("KH"));
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: got out_valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_midstream;
        install_key(KEY_GOOD);
        bus.out_ready = 1'b0;
        send({8'h00, "H"}, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.key_installed !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got v=%b %h inst=%b expected 0 0000 0", bus.out_valid, bus.out_data, bus.key_installed);
        end
        @(posedge clk); #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        install_key(KEY_GOOD);
        send({8'h00, "H"}, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== "CD") begin
            errors++;
            $display("FAIL post_reset: got v=%b %h expected v=1 %h", bus.out_valid, bus.out_data, 16'("CD"));
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.key       = '0;
        bus.key_valid = 1'b0;
        bus.mode      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_encrypt();
        test_decrypt();
        test_illegal_symbol();
        test_invalid_key();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
